// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: ALU opcodes, FSM encoding, width helper.
// Optional build macro ALU_ARB_FIXED_PRIO_EN is consumed by alu_rr_arbiter and alu_share_ctrl.
package alu_pkg;

  localparam logic [2:0] ALU_OP_AND = 3'd0;
  localparam logic [2:0] ALU_OP_OR  = 3'd1;
  localparam logic [2:0] ALU_OP_XOR = 3'd2;
  localparam logic [2:0] ALU_OP_NOR = 3'd3;
  localparam logic [2:0] ALU_OP_ADD = 3'd4;
  localparam logic [2:0] ALU_OP_SUB = 3'd5;
  localparam logic [2:0] ALU_OP_SLT = 3'd6;
  localparam logic [2:0] ALU_OP_SLL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Pointer/index width; never below 1 so NREQ=1 still gets a legal vector.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter: request vector plus start pointer -> one-hot grant and winner index.
// With ALU_ARB_FIXED_PRIO_EN defined the pointer is ignored and the lowest index wins.
module alu_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o,
  output logic            any_o
);

  int start;

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
  assign start      = 0;
`else
  assign start = int'(ptr_i);
`endif

  always_comb begin
    logic [PW-1:0] j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = '0;
    // Search wraps from NREQ-1 back to 0; first asserted request wins.
    for (int k = 0; k < NREQ; k++) begin
      j = PW'((start + k) % NREQ);
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external ALU between NREQ requesters: arbitrate, register operands, return F/ZF/OF.
// Build macro ALU_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*3-1:0] req_op,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_f,
  output logic              rsp_zf,
  output logic              rsp_of,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [2:0]        alu_op,
  input  logic [W-1:0]      alu_f,
  input  logic              alu_zf,
  input  logic              alu_of,
  output logic [1:0]        dbg_state
);

  localparam int PW = clog2_min1(NREQ);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // req_ready is only offered in IDLE, rsp_valid only in RESP, so the two never coincide.

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, gnt_q, gnt_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, f_q, f_d;
  logic [2:0]      op_q, op_d;
  logic            zf_q, zf_d, of_q, of_d;
  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic            arb_any;

  alu_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      f_q     <= '0;
      zf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      f_q     <= f_d;
      zf_q    <= zf_d;
      of_q    <= of_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    f_d       = f_q;
    zf_d      = zf_q;
    of_d      = of_q;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          req_ready = arb_gnt;
          gnt_d     = arb_idx;
          a_d       = req_a[int'(arb_idx)*W +: W];
          b_d       = req_b[int'(arb_idx)*W +: W];
          op_d      = req_op[int'(arb_idx)*3 +: 3];
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        f_d     = alu_f;
        zf_d    = alu_zf;
        of_d    = alu_of;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        if (rsp_ready[gnt_q]) begin
          state_d = ST_IDLE;
`ifdef ALU_ARB_FIXED_PRIO_EN
          ptr_d = '0;
`else
          ptr_d = (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + PW'(1);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign rsp_f     = f_q;
  assign rsp_zf    = zf_q;
  assign rsp_of    = of_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl with a behavioural ALU and a transaction-level model.
// Honours ALU_ARB_FIXED_PRIO_EN for the expected arbitration order.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int NREQ = 2;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ*3-1:0] req_op;
  logic [W-1:0]      rsp_f, alu_a, alu_b, alu_f;
  logic              rsp_zf, rsp_of, alu_zf, alu_of;
  logic [2:0]        alu_op;
  logic [1:0]        dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  alu_share_ctrl #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_f(rsp_f), .rsp_zf(rsp_zf), .rsp_of(rsp_of),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_f(alu_f), .alu_zf(alu_zf), .alu_of(alu_of),
    .dbg_state(dbg_state)
  );

  // Behavioural ALU: returns {OF, ZF, F}; OF is carry for ADD and borrow for SUB.
  function automatic logic [W+1:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] f;
    logic         of;
    f  = '0;
    of = 1'b0;
    s  = '0;
    case (op)
      ALU_OP_AND: f = a & b;
      ALU_OP_OR:  f = a | b;
      ALU_OP_XOR: f = a ^ b;
      ALU_OP_NOR: f = ~(a | b);
      ALU_OP_ADD: begin s = {1'b0, a} + {1'b0, b}; f = s[W-1:0]; of = s[W]; end
      ALU_OP_SUB: begin f = a - b; of = (a < b); end
      ALU_OP_SLT: f = ($signed(a) < $signed(b)) ? W'(1) : '0;
      default:    f = a << b[4:0];
    endcase
    return {of, (f == '0), f};
  endfunction

  assign {alu_of, alu_zf, alu_f} = alu_ref(alu_op, alu_a, alu_b);

  // ---------------- scoreboard / model ----------------
  int               n_assert = 0;
  int               n_fail   = 0;
  logic [W+1:0]     exp_q[$];
  int               grant_log[$];
  bit               busy = 0;
  int               cur_g = 0, acc_cyc = 0, cyc = 0, ptr_m = 0;
  logic [W-1:0]     last_a = '0, last_b = '0;
  logic [2:0]       last_op = '0;
  logic [W+1:0]     last_rsp = '0;
  logic [NREQ-1:0]  acc_now = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // Checks one cycle against the model, then advances the model across the coming edge.
  task automatic cycle_check();
    logic [NREQ-1:0] exp_ready, exp_rv;
    int g;
    acc_now = '0;
    if (rst) begin
      busy = 0; ptr_m = 0; last_a = '0; last_b = '0; last_op = '0; last_rsp = '0;
      exp_q.delete();
      cyc++;
      return;
    end
    exp_ready = '0;
    exp_rv    = '0;
    g         = pick(req_valid, ptr_m);
    if (!busy && g >= 0) exp_ready[g] = 1'b1;
    if (busy && cyc >= acc_cyc + 2) exp_rv[cur_g] = 1'b1;
    check("req_ready", req_ready, exp_ready);
    check("rsp_valid", rsp_valid, exp_rv);
    check("alu_ops", {alu_op, alu_a, alu_b}, {last_op, last_a, last_b});
    check("rsp_out", {rsp_of, rsp_zf, rsp_f}, last_rsp);
    if (!busy && g >= 0) begin
      busy    = 1; cur_g = g; acc_cyc = cyc; acc_now[g] = 1'b1;
      grant_log.push_back(g);
      last_a  = req_a[g*W +: W];
      last_b  = req_b[g*W +: W];
      last_op = req_op[g*3 +: 3];
      exp_q.push_back(alu_ref(last_op, last_a, last_b));
    end else if (busy && cyc == acc_cyc + 1) begin
      last_rsp = exp_q[0];
    end else if (busy && cyc >= acc_cyc + 2 && rsp_ready[cur_g]) begin
      void'(exp_q.pop_front());
      busy = 0;
`ifdef ALU_ARB_FIXED_PRIO_EN
      ptr_m = 0;
`else
      ptr_m = (cur_g + 1) % NREQ;
`endif
    end
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    #1;
    cycle_check();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    req_valid[i]       = 1'b1;
    req_a[i*W +: W]    = a;
    req_b[i*W +: W]    = b;
    req_op[i*3 +: 3]   = op;
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(0, 40));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic drain();
    req_valid = '0;
    rsp_ready = '1;
    for (int k = 0; k < 10 && busy; k++) tick();
    check("drain_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic single(input int r, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W+1:0] exp);
    logic [NREQ-1:0] one;
    one = '0;
    one[r] = 1'b1;
    set_req(r, op, a, b);
    #1 check("single_accept", req_ready, one);
    tick();
    req_valid[r] = 1'b0;
    tick();
    #1 check("single_rsp_valid", rsp_valid, one);
    check("single_result", {rsp_of, rsp_zf, rsp_f}, exp);
    tick();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int exp_g[4];
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = '1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, '0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_alu", {alu_op, alu_a, alu_b}, '0);
    check("rst_rsp", {rsp_of, rsp_zf, rsp_f}, '0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    #1 check("idle_state", dbg_state, 64'(ST_IDLE));

    // Basic results and flag corners
    single(0, ALU_OP_ADD, 32'd5, 32'd3, {1'b0, 1'b0, 32'd8});
    single(0, ALU_OP_ADD, 32'hFFFF_FFFF, 32'd1, {1'b1, 1'b1, 32'd0});
    single(1, ALU_OP_SUB, 32'd7, 32'd7, {1'b0, 1'b1, 32'd0});

    // Both requesters continuously valid
    grant_log.delete();
    set_req(0, ALU_OP_AND, rand_operand(), rand_operand());
    set_req(1, ALU_OP_OR,  rand_operand(), rand_operand());
    for (int n = 0; n < 12; n++) begin
      tick();
      for (int i = 0; i < NREQ; i++)
        if (acc_now[i]) set_req(i, 3'($urandom_range(0, 7)), rand_operand(), rand_operand());
    end
    drain();
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    check("grant_count", grant_log.size(), 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check($sformatf("grant_order_%0d", k), grant_log[k], exp_g[k]);

    // Response back-pressure while the other requester waits
    rsp_ready = 2'b10;
    set_req(0, ALU_OP_ADD, 32'h1234_0000, 32'h0000_5678);
    tick();
    req_valid[0] = 1'b0;
    set_req(1, ALU_OP_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    tick();
    repeat (5) tick();
    rsp_ready = 2'b11;
    tick();
    #1 check("stall_release_grant", req_ready, 2'b10);
    tick();
    drain();

    // Reset pulse while an operation is in EXEC
    single(0, ALU_OP_NOR, 32'd1, 32'd2, {1'b0, 1'b0, 32'hFFFF_FFFC});
    set_req(0, ALU_OP_OR, 32'hAAAA_0000, 32'h0000_5555);
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst_exec_alu", {alu_op, alu_a, alu_b}, '0);
    check("rst_exec_rsp", {rsp_valid, rsp_of, rsp_zf, rsp_f}, '0);
    repeat (4) tick();
    set_req(0, ALU_OP_SLT, 32'hFFFF_FFFF, 32'd1);
    set_req(1, ALU_OP_SLL, 32'd1, 32'd31);
    #1 check("post_rst_grant", req_ready, 2'b01);
    tick();
    drain();

    // Randomised traffic with random response back-pressure
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (acc_now[i]) req_valid[i] = 1'b0;
        if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0)
            set_req(i, 3'($urandom_range(0, 7)), rand_operand(), rand_operand());
        end else if (!acc_now[i] && $urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      tick();
    end
    drain();
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
